// File: rtl/ps2_scan_ctrl.sv
// PS/2 set-2 scan-code sequencer: pops FIFO bytes, folds E0/F0 prefixes
// into clean make/break events, tracks the held key and press count.
module ps2_scan_ctrl #(
  parameter int CNT_W       = 8,
  parameter bit DROP_REPEAT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  input  logic             ovf_clr,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_break,
  output logic             held_valid,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_sticky
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_SETTLE
  } state_t;

  state_t           state_q, state_d;
  logic             ndn_q, ndn_d;
  logic             kv_q, kv_d;
  logic [7:0]       kc_q, kc_d;
  logic             ke_q, ke_d;
  logic             kb_q, kb_d;
  logic             hv_q, hv_d;
  logic [7:0]       hc_q, hc_d;
  logic             he_q, he_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ext_pend_q, ext_pend_d;
  logic             brk_pend_q, brk_pend_d;

  logic is_e0;
  logic is_f0;
  logic hit;

  assign is_e0 = (data == 8'hE0);
  assign is_f0 = (data == 8'hF0);
  assign hit   = hv_q && (hc_q == data)
              && (he_q == ext_pend_q);

  always_comb begin
    state_d    = state_q;
    ndn_d      = 1'b1;
    kv_d       = 1'b0;
    kc_d       = kc_q;
    ke_d       = ke_q;
    kb_d       = kb_q;
    hv_d       = hv_q;
    hc_d       = hc_q;
    he_d       = he_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;

    unique case (state_q)
      S_IDLE: begin
        if (en && ready) begin
          state_d = S_POP;
          ndn_d   = 1'b0;
        end
      end
      S_POP: begin
        state_d = S_SETTLE;
        unique case (1'b1)
          is_e0: ext_pend_d = 1'b1;
          is_f0: brk_pend_d = 1'b1;
          default: begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
            if (brk_pend_q) begin
              kv_d = 1'b1;
              kc_d = data;
              ke_d = ext_pend_q;
              kb_d = 1'b1;
              if (hit) hv_d = 1'b0;
            end else if (hit) begin
              if (!DROP_REPEAT) begin
                kv_d = 1'b1;
                kc_d = data;
                ke_d = ext_pend_q;
                kb_d = 1'b0;
              end
            end else begin
              kv_d  = 1'b1;
              kc_d  = data;
              ke_d  = ext_pend_q;
              kb_d  = 1'b0;
              hv_d  = 1'b1;
              hc_d  = data;
              he_d  = ext_pend_q;
              cnt_d = cnt_q + 1'b1;
            end
          end
        endcase
      end
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // a lost byte makes any pending prefix meaningless
    if (overflow) begin
      ovf_d      = 1'b1;
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ndn_q      <= 1'b1;
      kv_q       <= 1'b0;
      kc_q       <= 8'h00;
      ke_q       <= 1'b0;
      kb_q       <= 1'b0;
      hv_q       <= 1'b0;
      hc_q       <= 8'h00;
      he_q       <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ndn_q      <= ndn_d;
      kv_q       <= kv_d;
      kc_q       <= kc_d;
      ke_q       <= ke_d;
      kb_q       <= kb_d;
      hv_q       <= hv_d;
      hc_q       <= hc_d;
      he_q       <= he_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
    end
  end

  assign nextdata_n = ndn_q;
  assign key_valid  = kv_q;
  assign key_code   = kc_q;
  assign key_ext    = ke_q;
  assign key_break  = kb_q;
  assign held_valid = hv_q;
  assign held_code  = hc_q;
  assign held_ext   = he_q;
  assign press_cnt  = cnt_q;
  assign ovf_sticky = ovf_q;

endmodule
